// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - dual-write, dual-read register file with write bypass
// and a one-entry-per-cycle clear sweep.
module regfile_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we1,
  input  logic [ADDR_W-1:0] waddr1,
  input  logic [DATA_W-1:0] wdata1,
  input  logic              we2,
  input  logic [ADDR_W-1:0] waddr2,
  input  logic [DATA_W-1:0] wdata2,
  input  logic [ADDR_W-1:0] raddr1,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2,
  input  logic              clr_req,
  output logic              busy
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t            state_q;
  logic              busy_q;
  logic [ADDR_W-1:0] cnt_q;
  logic [ADDR_W-1:0] cnt_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic              wr1_en;
  logic              wr2_en;

  assign wr1_en = we1 && !busy_q && !((ZERO_REG != 0) && (waddr1 == '0));
  assign wr2_en = we2 && !busy_q && !((ZERO_REG != 0) && (waddr2 == '0));
  assign cnt_d  = cnt_q + ADDR_W'(1);
  assign busy   = busy_q;

  // Port 2 is assigned last so it wins a same-address collision.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      cnt_q   <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (wr1_en) mem_q[waddr1] <= wdata1;
          if (wr2_en) mem_q[waddr2] <= wdata2;
          if (clr_req) begin
            state_q <= CLEAR;
            busy_q  <= 1'b1;
            cnt_q   <= '0;
          end
        end
        CLEAR: begin
          mem_q[cnt_q] <= '0;
          cnt_q        <= cnt_d;
          if (cnt_q == ADDR_W'(DEPTH - 1)) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Forwarding is suppressed during the sweep since writes are being dropped.
  always_comb begin
    rdata1 = mem_q[raddr1];
    if ((BYPASS != 0) && !busy_q) begin
      if (we1 && (waddr1 == raddr1)) rdata1 = wdata1;
      if (we2 && (waddr2 == raddr1)) rdata1 = wdata2;
    end
    if (rst || ((ZERO_REG != 0) && (raddr1 == '0))) rdata1 = '0;
  end

  always_comb begin
    rdata2 = mem_q[raddr2];
    if ((BYPASS != 0) && !busy_q) begin
      if (we1 && (waddr1 == raddr2)) rdata2 = wdata1;
      if (we2 && (waddr2 == raddr2)) rdata2 = wdata2;
    end
    if (rst || ((ZERO_REG != 0) && (raddr2 == '0))) rdata2 = '0;
  end

endmodule
